conv_layer_seq: RTL and testbench
=================================

CONV_LAYER_SEQ -- requirements
Module: conv_layer_seq

Interface
REQ-001 SHALL have parameter NUM_INPUTS, default 1, input channel count.
REQ-002 SHALL have parameter INPUT_DIM, default 5, input feature-map side.
REQ-003 SHALL have parameter NUM_OUTPUTS, default 1, output channel count.
REQ-004 SHALL have parameter KERNEL_DIM, default 3, kernel side; OUTPUT_DIM = INPUT_DIM-KERNEL_DIM+1, derived.
REQ-005 SHALL have parameter DATA_SIZE, default 64, word width (IEEE-754 double bits).
REQ-006 SHALL have parameter TIMEOUT, default 65535, maximum wait cycles for compute done.
REQ-007 Ports: clk in 1 clock; rst_n in 1 synchronous active-low reset.
REQ-008 Ports: start in 1 begin frame; busy out 1 frame in progress; error out 1 sticky timeout flag.
REQ-009 Ports: in_valid in 1, in_ready out 1, in_data in DATA_SIZE: load stream (weights, biases, activations).
REQ-010 Ports: out_valid out 1, out_ready in 1, out_data out DATA_SIZE, out_last out 1: result stream.
REQ-011 Datapath ports out: want_write_weights, want_write_bias, want_write_act (1); write_data, write_data_act (DATA_SIZE); in_index3..0, act_index2..0 (16 each); compute (1); read_outmem_index[2:0] (16 each).
REQ-012 Datapath ports in: outmem_out_data DATA_SIZE, output_valid 1.

Function
REQ-013 States SHALL be IDLE, LOAD_W, LOAD_B, LOAD_A, START, WAIT, DRAIN, DONE.
REQ-014 IDLE: start=1 -> LOAD_W next cycle; start ignored in all other states.
REQ-015 A load word SHALL transfer only on a cycle with in_valid&in_ready; the matching want_write_* pulses that cycle with write_data/write_data_act = in_data.
REQ-016 in_ready SHALL be 1 only in LOAD_W, LOAD_B, LOAD_A.
REQ-017 LOAD_W order: in_index0 (kx) fastest, then in_index1 (ky), in_index3 (input ch), in_index2 (output ch) slowest; NUM_OUTPUTS*NUM_INPUTS*KERNEL_DIM^2 words, then LOAD_B.
REQ-018 LOAD_B: NUM_OUTPUTS words, in_index2 = 0..NUM_OUTPUTS-1, then LOAD_A.
REQ-019 LOAD_A: act_index0 (x) fastest, act_index1 (y), act_index2 (entry) slowest; NUM_INPUTS*INPUT_DIM^2 words, then START.
REQ-020 START: compute=1 for exactly 2 consecutive cycles (releases datapath done state, then launches), then WAIT.
REQ-021 WAIT: cycle counter from 0; done when counter >= 3*NUM_OUTPUTS*OUTPUT_DIM^2 and output_valid=1 -> DRAIN; counter = TIMEOUT first -> error=1, DONE.
REQ-022 DRAIN: read_outmem_index[0] (x) fastest, [1] (y), [2] (entry) slowest; outmem_out_data valid 1 cycle after index presented.
REQ-023 DRAIN SHALL buffer read data in a 2-entry skid so out_ready=0 never loses or duplicates a word; index advances only with buffer space.
REQ-024 out_last=1 with the final word (index NUM_OUTPUTS-1, OUTPUT_DIM-1, OUTPUT_DIM-1); its handshake -> DONE.
REQ-025 DONE: one cycle, then IDLE; busy=1 in every state except IDLE.
REQ-026 Index counters SHALL wrap to 0 at their bound with carry into the next field; unused index outputs hold 0.
REQ-027 out_valid and want_write_* SHALL never be asserted outside DRAIN/load states respectively.

Reset
REQ-028 rst_n=0 at a clk edge: state IDLE; all indices, counters, skid buffer cleared; in_ready, out_valid, out_last, compute, want_write_*, busy, error = 0; write_data = 0.
REQ-029 Reset mid-frame SHALL abort immediately; no further datapath write or compute pulse after the reset edge.
REQ-030 error SHALL clear only by reset.

Configuration
REQ-031 Macro CONV_SEQ_WEIGHT_REUSE_EN defined: extra input reuse_weights (1); if 1 when start accepted, IDLE -> LOAD_A directly, skipping LOAD_W/LOAD_B.
REQ-032 Macro undefined: port absent; every frame loads weights and biases.

Structure
REQ-033 Shared package conv_seq_pkg SHALL hold the state enum and localparam word-count/latency formulas.
REQ-034 One sub-module conv_seq_skid (2-entry output skid buffer); the rest is a single FSM.

Verification
REQ-035 NUM_INPUTS=1, INPUT_DIM=5, KERNEL_DIM=3, NUM_OUTPUTS=1; 9 weights 1.0, bias 0.5, 25 acts 1.0 -> 9 outputs 9.5 (0x4023000000000000), out_last on 9th.
REQ-036 in_valid toggled 1/0 every cycle during load -> exactly 35 want_write pulses, indices in REQ-017..019 order.
REQ-037 out_ready low 3 cycles of every 4 during DRAIN -> all 9 words in order, no drop/duplicate.
REQ-038 output_valid held 0, TIMEOUT=100 -> error=1 at counter 100, DONE then IDLE, no out_valid.
REQ-039 rst_n=0 during LOAD_A word 10 -> next cycle IDLE, all outputs 0; new start runs a full correct frame.
REQ-040 With CONV_SEQ_WEIGHT_REUSE_EN, second frame reuse_weights=1, acts 2.0 -> no weight/bias writes, outputs 18.5.

Source files
------------

// File: rtl/conv_seq_pkg.sv
// Shared FSM state type and sizing helpers for conv_layer_seq.
// Imported by conv_layer_seq and conv_seq_skid.
package conv_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_LOAD_B,
    S_LOAD_A,
    S_START,
    S_WAIT,
    S_DRAIN,
    S_DONE
  } state_e;

  localparam int IDX_W        = 16;
  localparam int CNT_W        = 32;
  localparam int START_CYCLES = 2;
  localparam int CYC_PER_OUT  = 3;

  function automatic int out_dim(input int in_dim, input int k_dim);
    return in_dim - k_dim + 1;
  endfunction

  function automatic int min_wait(input int n_out, input int o_dim);
    return CYC_PER_OUT * n_out * o_dim * o_dim;
  endfunction

endpackage

// File: rtl/conv_seq_skid.sv
// Two-entry output skid buffer; holds words read from the output
// memory while the result stream is stalled.
module conv_seq_skid
  import conv_seq_pkg::*;
#(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         push_last,
  input  logic         pop,
  output logic         valid,
  output logic [W-1:0] data,
  output logic         last,
  output logic [1:0]   count
);

  logic [W:0] mem_q [2];
  logic [W:0] mem_d [2];
  logic       rd_q, rd_d;
  logic       wr_q, wr_d;
  logic [1:0] cnt_q, cnt_d;
  logic       do_pop, do_push;

  always_comb begin
    do_pop  = pop && (cnt_q != 2'd0);
    do_push = push && ((cnt_q != 2'd2) || do_pop);
    mem_d   = mem_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    if (do_push) begin
      mem_d[wr_q] = {push_last, push_data};
      wr_d        = ~wr_q;
    end
    if (do_pop) begin
      rd_d = ~rd_q;
    end
    cnt_d = cnt_q + {1'b0, do_push} - {1'b0, do_pop};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      mem_q <= mem_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  assign valid = (cnt_q != 2'd0);
  assign data  = valid ? mem_q[rd_q][W-1:0] : '0;
  assign last  = valid && mem_q[rd_q][W];
  assign count = cnt_q;

endmodule

// File: rtl/conv_layer_seq.sv
// Frame sequencer for a convolution datapath: load, compute, drain.
// Define CONV_SEQ_WEIGHT_REUSE_EN to add the reuse_weights input.
module conv_layer_seq
  import conv_seq_pkg::*;
#(
  parameter int NUM_INPUTS  = 1,
  parameter int INPUT_DIM   = 5,
  parameter int NUM_OUTPUTS = 1,
  parameter int KERNEL_DIM  = 3,
  parameter int DATA_SIZE   = 64,
  parameter int TIMEOUT     = 65535
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
`ifdef CONV_SEQ_WEIGHT_REUSE_EN
  input  logic                  reuse_weights,
`endif
  output logic                  busy,
  output logic                  error,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_SIZE-1:0]  in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_SIZE-1:0]  out_data,
  output logic                  out_last,
  output logic                  want_write_weights,
  output logic                  want_write_bias,
  output logic                  want_write_act,
  output logic [DATA_SIZE-1:0]  write_data,
  output logic [DATA_SIZE-1:0]  write_data_act,
  output logic [IDX_W-1:0]      in_index3,
  output logic [IDX_W-1:0]      in_index2,
  output logic [IDX_W-1:0]      in_index1,
  output logic [IDX_W-1:0]      in_index0,
  output logic [IDX_W-1:0]      act_index2,
  output logic [IDX_W-1:0]      act_index1,
  output logic [IDX_W-1:0]      act_index0,
  output logic                  compute,
  output logic [2:0][IDX_W-1:0] read_outmem_index,
  input  logic [DATA_SIZE-1:0]  outmem_out_data,
  input  logic                  output_valid
);

  localparam int OUTPUT_DIM = out_dim(INPUT_DIM, KERNEL_DIM);

  localparam logic [CNT_W-1:0] MIN_WAIT =
    CNT_W'(min_wait(NUM_OUTPUTS, OUTPUT_DIM));
  localparam logic [CNT_W-1:0] TMO    = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ST_END = CNT_W'(START_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

  localparam logic [IDX_W-1:0] K_MAX  = IDX_W'(KERNEL_DIM - 1);
  localparam logic [IDX_W-1:0] NI_MAX = IDX_W'(NUM_INPUTS - 1);
  localparam logic [IDX_W-1:0] NO_MAX = IDX_W'(NUM_OUTPUTS - 1);
  localparam logic [IDX_W-1:0] ID_MAX = IDX_W'(INPUT_DIM - 1);
  localparam logic [IDX_W-1:0] OD_MAX = IDX_W'(OUTPUT_DIM - 1);
  localparam logic [IDX_W-1:0] I_ONE  = IDX_W'(1);

  state_e state_q, state_d;

  logic [IDX_W-1:0] wi0_q, wi0_d, wi1_q, wi1_d;
  logic [IDX_W-1:0] wi2_q, wi2_d, wi3_q, wi3_d;
  logic [IDX_W-1:0] ai0_q, ai0_d, ai1_q, ai1_d, ai2_q, ai2_d;
  logic [IDX_W-1:0] ri0_q, ri0_d, ri1_q, ri1_d, ri2_q, ri2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             rd_done_q, rd_done_d;
  logic             pend_q, pend_d;
  logic             pend_last_q, pend_last_d;

  logic       reuse;
  logic       rdy, xfer;
  logic       ww, wb, wa, cmp;
  logic       sk_valid, sk_last, sk_pop, pop_now;
  logic [1:0] sk_count;
  logic [2:0] occ;
  logic       rd_last;
  logic [DATA_SIZE-1:0] sk_data;

`ifdef CONV_SEQ_WEIGHT_REUSE_EN
  assign reuse = reuse_weights;
`else
  assign reuse = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    wi0_d       = wi0_q;
    wi1_d       = wi1_q;
    wi2_d       = wi2_q;
    wi3_d       = wi3_q;
    ai0_d       = ai0_q;
    ai1_d       = ai1_q;
    ai2_d       = ai2_q;
    ri0_d       = ri0_q;
    ri1_d       = ri1_q;
    ri2_d       = ri2_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    rd_done_d   = rd_done_q;
    pend_d      = 1'b0;
    pend_last_d = 1'b0;
    rdy         = 1'b0;
    ww          = 1'b0;
    wb          = 1'b0;
    wa          = 1'b0;
    cmp         = 1'b0;
    sk_pop      = 1'b0;
    pop_now     = 1'b0;
    occ         = 3'd0;
    rd_last     = (ri0_q == OD_MAX) && (ri1_q == OD_MAX) &&
                  (ri2_q == NO_MAX);
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = reuse ? S_LOAD_A : S_LOAD_W;
        end
      end
      S_LOAD_W: begin
        rdy = rst_n;
        if (in_valid && rdy) begin
          ww    = 1'b1;
          wi0_d = wi0_q + I_ONE;
          if (wi0_q == K_MAX) begin
            wi0_d = '0;
            wi1_d = wi1_q + I_ONE;
            if (wi1_q == K_MAX) begin
              wi1_d = '0;
              wi3_d = wi3_q + I_ONE;
              if (wi3_q == NI_MAX) begin
                wi3_d = '0;
                wi2_d = wi2_q + I_ONE;
                if (wi2_q == NO_MAX) begin
                  wi2_d   = '0;
                  state_d = S_LOAD_B;
                end
              end
            end
          end
        end
      end
      S_LOAD_B: begin
        rdy = rst_n;
        if (in_valid && rdy) begin
          wb    = 1'b1;
          wi2_d = wi2_q + I_ONE;
          if (wi2_q == NO_MAX) begin
            wi2_d   = '0;
            state_d = S_LOAD_A;
          end
        end
      end
      S_LOAD_A: begin
        rdy = rst_n;
        if (in_valid && rdy) begin
          wa    = 1'b1;
          ai0_d = ai0_q + I_ONE;
          if (ai0_q == ID_MAX) begin
            ai0_d = '0;
            ai1_d = ai1_q + I_ONE;
            if (ai1_q == ID_MAX) begin
              ai1_d = '0;
              ai2_d = ai2_q + I_ONE;
              if (ai2_q == NI_MAX) begin
                ai2_d   = '0;
                cnt_d   = '0;
                state_d = S_START;
              end
            end
          end
        end
      end
      S_START: begin
        // first pulse clears datapath done, second launches it
        cmp = rst_n;
        if (cnt_q == ST_END) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end else begin
          cnt_d = cnt_q + C_ONE;
        end
      end
      S_WAIT: begin
        if ((cnt_q >= MIN_WAIT) && output_valid) begin
          cnt_d     = '0;
          rd_done_d = 1'b0;
          state_d   = S_DRAIN;
        end else if (cnt_q == TMO) begin
          cnt_d   = '0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + C_ONE;
        end
      end
      S_DRAIN: begin
        sk_pop  = out_ready;
        pop_now = out_ready && sk_valid;
        // count the read still in flight so the skid never overflows
        occ = {1'b0, sk_count} + {2'b00, pend_q} - {2'b00, pop_now};
        if (!rd_done_q && (occ < 3'd2)) begin
          pend_d      = 1'b1;
          pend_last_d = rd_last;
          ri0_d       = ri0_q + I_ONE;
          if (ri0_q == OD_MAX) begin
            ri0_d = '0;
            ri1_d = ri1_q + I_ONE;
            if (ri1_q == OD_MAX) begin
              ri1_d = '0;
              ri2_d = ri2_q + I_ONE;
              if (ri2_q == NO_MAX) begin
                ri2_d     = '0;
                rd_done_d = 1'b1;
              end
            end
          end
        end
        if (pop_now && sk_last) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wi0_q       <= '0;
      wi1_q       <= '0;
      wi2_q       <= '0;
      wi3_q       <= '0;
      ai0_q       <= '0;
      ai1_q       <= '0;
      ai2_q       <= '0;
      ri0_q       <= '0;
      ri1_q       <= '0;
      ri2_q       <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      rd_done_q   <= 1'b0;
      pend_q      <= 1'b0;
      pend_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wi0_q       <= wi0_d;
      wi1_q       <= wi1_d;
      wi2_q       <= wi2_d;
      wi3_q       <= wi3_d;
      ai0_q       <= ai0_d;
      ai1_q       <= ai1_d;
      ai2_q       <= ai2_d;
      ri0_q       <= ri0_d;
      ri1_q       <= ri1_d;
      ri2_q       <= ri2_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      rd_done_q   <= rd_done_d;
      pend_q      <= pend_d;
      pend_last_q <= pend_last_d;
    end
  end

  conv_seq_skid #(
    .W(DATA_SIZE)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (pend_q),
    .push_data(outmem_out_data),
    .push_last(pend_last_q),
    .pop      (sk_pop),
    .valid    (sk_valid),
    .data     (sk_data),
    .last     (sk_last),
    .count    (sk_count)
  );

  assign xfer               = in_valid && rdy;
  assign in_ready           = rdy;
  assign want_write_weights = ww;
  assign want_write_bias    = wb;
  assign want_write_act     = wa;
  assign write_data         = (ww || wb) ? in_data : '0;
  assign write_data_act     = (wa && xfer) ? in_data : '0;
  assign compute            = cmp;
  assign busy               = (state_q != S_IDLE);
  assign error              = err_q;
  assign out_valid          = sk_valid && (state_q == S_DRAIN);
  assign out_data           = out_valid ? sk_data : '0;
  assign out_last           = out_valid && sk_last;

  assign in_index0  = wi0_q;
  assign in_index1  = wi1_q;
  assign in_index2  = wi2_q;
  assign in_index3  = wi3_q;
  assign act_index0 = ai0_q;
  assign act_index1 = ai1_q;
  assign act_index2 = ai2_q;

  assign read_outmem_index[0] = ri0_q;
  assign read_outmem_index[1] = ri1_q;
  assign read_outmem_index[2] = ri2_q;

endmodule

// File: tb/tb_conv_layer_seq.sv
// Directed bench for conv_layer_seq with a behavioural conv datapath.
// Define CONV_SEQ_WEIGHT_REUSE_EN to add the weight-reuse frame.
module tb_conv_layer_seq;

  localparam int NI = 1;
  localparam int ID = 5;
  localparam int NO = 1;
  localparam int KD = 3;
  localparam int OD = 3;
  localparam int TO = 100;

  localparam logic [63:0] R1P0  = 64'h3FF0000000000000;
  localparam logic [63:0] R0P5  = 64'h3FE0000000000000;
  localparam logic [63:0] R2P0  = 64'h4000000000000000;
  localparam logic [63:0] R9P5  = 64'h4023000000000000;
  localparam logic [63:0] R18P5 = 64'h4032800000000000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
`ifdef CONV_SEQ_WEIGHT_REUSE_EN
  logic        reuse_weights = 1'b0;
`endif
  logic        busy, error;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_data;
  logic        out_last;
  logic        want_write_weights, want_write_bias, want_write_act;
  logic [63:0] write_data, write_data_act;
  logic [15:0] in_index3, in_index2, in_index1, in_index0;
  logic [15:0] act_index2, act_index1, act_index0;
  logic        compute;
  logic [2:0][15:0] read_outmem_index;
  logic [63:0] outmem_out_data = '0;
  logic        output_valid;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  conv_layer_seq #(
    .NUM_INPUTS (NI),
    .INPUT_DIM  (ID),
    .NUM_OUTPUTS(NO),
    .KERNEL_DIM (KD),
    .DATA_SIZE  (64),
    .TIMEOUT    (TO)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start),
`ifdef CONV_SEQ_WEIGHT_REUSE_EN
    .reuse_weights     (reuse_weights),
`endif
    .busy              (busy),
    .error             (error),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_data           (in_data),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_data          (out_data),
    .out_last          (out_last),
    .want_write_weights(want_write_weights),
    .want_write_bias   (want_write_bias),
    .want_write_act    (want_write_act),
    .write_data        (write_data),
    .write_data_act    (write_data_act),
    .in_index3         (in_index3),
    .in_index2         (in_index2),
    .in_index1         (in_index1),
    .in_index0         (in_index0),
    .act_index2        (act_index2),
    .act_index1        (act_index1),
    .act_index0        (act_index0),
    .compute           (compute),
    .read_outmem_index (read_outmem_index),
    .outmem_out_data   (outmem_out_data),
    .output_valid      (output_valid)
  );

  // behavioural datapath: stores loads, convolves on launch
  logic [63:0] w_mem [KD*KD];
  logic [63:0] b_mem = '0;
  logic [63:0] a_mem [ID*ID];
  logic [63:0] o_mem [OD*OD];
  int   n_ww = 0;
  int   n_wb = 0;
  int   n_wa = 0;
  int   dp_cnt = 0;
  logic dp_en = 1'b1;
  logic launched = 1'b0;
  logic cmp_d = 1'b0;

  function automatic real conv_at(input int ox, input int oy);
    real s;
    s = $bitstoreal(b_mem);
    for (int ky = 0; ky < KD; ky++)
      for (int kx = 0; kx < KD; kx++)
        s = s + $bitstoreal(w_mem[ky*KD+kx]) *
                $bitstoreal(a_mem[(oy+ky)*ID+ox+kx]);
    return s;
  endfunction

  always @(posedge clk) begin
    if (want_write_weights) begin
      w_mem[int'(in_index1)*KD+int'(in_index0)] <= write_data;
      n_ww <= n_ww + 1;
    end
    if (want_write_bias) begin
      b_mem <= write_data;
      n_wb <= n_wb + 1;
    end
    if (want_write_act) begin
      a_mem[int'(act_index1)*ID+int'(act_index0)] <= write_data_act;
      n_wa <= n_wa + 1;
    end
    if (compute && cmp_d)
      for (int y = 0; y < OD; y++)
        for (int x = 0; x < OD; x++)
          o_mem[y*OD+x] <= $realtobits(conv_at(x, y));
    if (compute) dp_cnt <= 0;
    else if (dp_cnt < 100000) dp_cnt <= dp_cnt + 1;
    launched <= launched | compute;
    cmp_d <= compute;
    if (int'(read_outmem_index[1]) < OD && int'(read_outmem_index[0]) < OD)
      outmem_out_data <=
        o_mem[int'(read_outmem_index[1])*OD+int'(read_outmem_index[0])];
    else
      outmem_out_data <= '0;
  end

  assign output_valid = dp_en && launched && !compute && (dp_cnt >= 30);

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] act_val(input int mode, input int x,
                                          input int y);
    if (mode == 1) return $realtobits(real'(x + 5*y));
    if (mode == 2) return R2P0;
    return R1P0;
  endfunction

  function automatic logic [63:0] exp_word(input int ev, input int k);
    if (ev == 1)
      return $realtobits(0.5 + 9.0*real'(k%OD + 1) + 45.0*real'(k/OD + 1));
    if (ev == 2) return R18P5;
    return R9P5;
  endfunction

  task automatic put_word(input logic [63:0] d, input int kind,
                          input int i0, input int i1, input int i2,
                          input int i3, input int a0, input int a1,
                          input int a2, input bit toggle);
    logic [2:0]   ew;
    logic [127:0] ei, oi;
    if (toggle) begin
      in_valid = 1'b0;
      in_data  = '0;
      #1;
      chk("gap_want", {want_write_weights, want_write_bias,
                       want_write_act}, 3'b000);
      step();
    end
    in_valid = 1'b1;
    in_data  = d;
    #1;
    ew = (kind == 0) ? 3'b100 : (kind == 1) ? 3'b010 : 3'b001;
    chk("in_ready", in_ready, 1'b1);
    chk("want", {want_write_weights, want_write_bias, want_write_act}, ew);
    chk("wdata", (kind == 2) ? write_data_act : write_data, d);
    ei = {16'h0, 16'(i3), 16'(i2), 16'(i1), 16'(i0),
          16'(a2), 16'(a1), 16'(a0)};
    oi = {16'h0, in_index3, in_index2, in_index1, in_index0,
          act_index2, act_index1, act_index0};
    chk("index", oi, ei);
    step();
    in_valid = 1'b0;
  endtask

  task automatic load_wb(input bit toggle);
    for (int o = 0; o < NO; o++)
      for (int i = 0; i < NI; i++)
        for (int ky = 0; ky < KD; ky++)
          for (int kx = 0; kx < KD; kx++)
            put_word(R1P0, 0, kx, ky, o, i, 0, 0, 0, toggle);
    for (int o = 0; o < NO; o++)
      put_word(R0P5, 1, 0, 0, o, 0, 0, 0, 0, toggle);
  endtask

  task automatic load_act(input bit toggle, input int mode, input int nmax);
    int n = 0;
    for (int e = 0; e < NI; e++)
      for (int y = 0; y < ID; y++)
        for (int x = 0; x < ID; x++)
          if (n < nmax) begin
            put_word(act_val(mode, x, y), 2, 0, 0, 0, 0, x, y, e, toggle);
            n++;
          end
  endtask

  task automatic start_frame();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_busy", busy, 1'b1);
  endtask

  task automatic recv_frame(input bit throttle, input int ev);
    int k = 0;
    int cyc = 0;
    while (k < OD*OD*NO && cyc < 400) begin
      out_ready = throttle ? (cyc % 4 == 3) : 1'b1;
      #1;
      if (out_valid && out_ready) begin
        chk($sformatf("out_data[%0d]", k), out_data, exp_word(ev, k));
        chk($sformatf("out_last[%0d]", k), out_last, (k == OD*OD*NO-1));
        k++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    out_ready = 1'b0;
    chk("drain_count", k, OD*OD*NO);
    chk("done_busy", busy, 1'b1);
    chk("done_no_ov", out_valid, 1'b0);
    step();
    chk("idle_busy", busy, 1'b0);
  endtask

  initial begin
    int bw, bb, ba;
    logic saw;

    // reset state
    rst_n = 1'b0;
    repeat (3) step();
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", error, 1'b0);
    chk("rst_ready", in_ready, 1'b0);
    chk("rst_ov", {out_valid, out_last, compute}, 3'b000);
    chk("rst_want", {want_write_weights, want_write_bias,
                     want_write_act}, 3'b000);
    chk("rst_wdata", write_data, 64'h0);
    chk("rst_idx", {in_index3, in_index2, in_index1, in_index0,
                    act_index2, act_index1, act_index0}, 112'h0);
    rst_n = 1'b1;
    step();

    // frame 1: toggled in_valid, all-ones activations
    bw = n_ww; bb = n_wb; ba = n_wa;
    start_frame();
    chk("loadw_ready", in_ready, 1'b1);
    load_wb(1'b1);
    load_act(1'b1, 0, NI*ID*ID);
    chk("write_pulses", (n_ww-bw) + (n_wb-bb) + (n_wa-ba), 35);
    chk("start_cmp0", {compute, in_ready}, 2'b10);
    step();
    chk("start_cmp1", compute, 1'b1);
    step();
    chk("wait_cmp", {compute, busy}, 2'b01);
    recv_frame(1'b0, 0);

    // frame 2: ramp activations, out_ready 1 cycle in 4
    start_frame();
    load_wb(1'b0);
    load_act(1'b0, 1, NI*ID*ID);
    recv_frame(1'b1, 1);

    // frame 3: datapath never finishes
    dp_en = 1'b0;
    saw = 1'b0;
    start_frame();
    load_wb(1'b0);
    load_act(1'b0, 0, NI*ID*ID);
    for (int c = 0; c < 102; c++) begin
      saw = saw | out_valid;
      step();
    end
    chk("tmo_wait", {busy, error}, 2'b10);
    step();
    chk("tmo_done", {busy, error}, 2'b11);
    step();
    chk("tmo_idle", {busy, error}, 2'b01);
    chk("tmo_no_ov", saw, 1'b0);
    dp_en = 1'b1;

    // frame 4: reset while presenting activation word 10
    start_frame();
    chk("err_sticky", error, 1'b1);
    load_wb(1'b0);
    ba = n_wa;
    load_act(1'b0, 0, 10);
    in_valid = 1'b1;
    in_data  = R1P0;
    rst_n    = 1'b0;
    step();
    chk("arst_busy", {busy, error, in_ready}, 3'b000);
    chk("arst_ctl", {out_valid, out_last, compute, want_write_weights,
                     want_write_bias, want_write_act}, 6'b0);
    chk("arst_wdata", {write_data, write_data_act}, 128'h0);
    chk("arst_idx", {in_index3, in_index2, in_index1, in_index0,
                     act_index2, act_index1, act_index0}, 112'h0);
    chk("arst_ridx", read_outmem_index, 48'h0);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    step();
    chk("arst_acts", n_wa - ba, 10);

    // frame 5: clean frame after abort
    start_frame();
    load_wb(1'b0);
    load_act(1'b0, 0, NI*ID*ID);
    recv_frame(1'b0, 0);

`ifdef CONV_SEQ_WEIGHT_REUSE_EN
    // frame 6: reuse stored weights, activations 2.0
    bw = n_ww; bb = n_wb;
    reuse_weights = 1'b1;
    start_frame();
    reuse_weights = 1'b0;
    load_act(1'b0, 2, NI*ID*ID);
    chk("reuse_no_wb", (n_ww-bw) + (n_wb-bb), 0);
    recv_frame(1'b0, 2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
